vdp_cpu_port: RTL

//  CPU-side access port of the VDP, upstream of the display engine. Decodes a 4-address CPU bus

---
 rtl/vdp_cpu_port_pkg.sv | 35 +++
 rtl/vdp_write_fifo.sv | 48 ++++
 rtl/vdp_cpu_port.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vdp_cpu_port_pkg.sv
// rtl/vdp_cpu_port_pkg.sv - shared port indices, status layout and prefetch states for the VDP CPU port
package vdp_cpu_port_pkg;

    localparam logic [1:0] PORT_DATA    = 2'd0;
    localparam logic [1:0] PORT_ADDR_LO = 2'd1;
    localparam logic [1:0] PORT_ADDR_HI = 2'd2;
    localparam logic [1:0] PORT_REG     = 2'd3;

    localparam int STAT_FULL       = 7;
    localparam int STAT_EMPTY      = 6;
    localparam int STAT_READ_VALID = 5;
    localparam int STAT_OVERFLOW   = 4;
    localparam int STAT_REG_PHASE  = 0;

    typedef enum logic [1:0] {
        PF_IDLE  = 2'd0,
        PF_WAITQ = 2'd1,
        PF_ISSUE = 2'd2,
        PF_CAPT  = 2'd3
    } pf_state_t;

    function automatic logic [7:0] pack_status(input logic full, input logic empty,
                                               input logic read_valid, input logic overflow,
                                               input logic reg_phase);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_FULL]       = full;
        s[STAT_EMPTY]      = empty;
        s[STAT_READ_VALID] = read_valid;
        s[STAT_OVERFLOW]   = overflow;
        s[STAT_REG_PHASE]  = reg_phase;
        return s;
    endfunction

endpackage

// File: rtl/vdp_write_fifo.sv
// rtl/vdp_write_fifo.sv - synchronous FIFO buffering CPU VRAM writes until a free slot
module vdp_write_fifo #(
    parameter int Width = 24,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] pushData,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] head
);

    localparam int PtrBits = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrBits:0] wrPtr;
    logic [PtrBits:0] rdPtr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[PtrBits] != rdPtr[PtrBits]) &&
                   (wrPtr[PtrBits-1:0] == rdPtr[PtrBits-1:0]);
    assign head  = mem[rdPtr[PtrBits-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wrPtr[PtrBits-1:0]] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push && !full) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop && !empty) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vdp_cpu_port.sv
// rtl/vdp_cpu_port.sv - CPU access port: address pointer, write FIFO drain, read-ahead and register writes
module vdp_cpu_port
    import vdp_cpu_port_pkg::*;
#(
    parameter int RamBits   = 16,
    parameter int FifoDepth = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         cpuAddr,
    input  logic               cpuWrite,
    input  logic               cpuRead,
    input  logic [7:0]         cpuDataIn,
    output logic [7:0]         cpuDataOut,
    input  logic               slotFree,
    output logic [RamBits-1:0] vramAddress,
    output logic [7:0]         vramDataOut,
    output logic               vramWrite,
    input  logic [7:0]         vramDataIn,
    output logic               regWrite,
    output logic [2:0]         regIndex,
    output logic [7:0]         regData
);

    logic [RamBits-1:0] addrPtr;
    logic               regPhase;
    logic [7:0]         regLatch;
    logic [7:0]         readBuf;
    logic               readValid;
    logic               overflow;
    pf_state_t          pfState;
    pf_state_t          pfNext;
    logic               pfIssue;
    logic               pfCapture;

    logic               fifoFull;
    logic               fifoEmpty;
    logic [RamBits+7:0] fifoHead;

    logic p0Write;
    logic p0Read;
    logic push;
    logic pop;
    logic pfStart;

    // A simultaneous write wins; the read strobe is then ignored.
    assign p0Write = cpuWrite && (cpuAddr == PORT_DATA);
    assign p0Read  = cpuRead && !cpuWrite && (cpuAddr == PORT_DATA);
    assign push    = p0Write && !fifoFull;
    assign pop     = slotFree && !fifoEmpty;
    assign pfStart = p0Read || (cpuWrite && (cpuAddr == PORT_ADDR_HI));

    vdp_write_fifo #(
        .Width(RamBits + 8),
        .Depth(FifoDepth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .pushData({addrPtr, cpuDataIn}),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .head    (fifoHead)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pfState <= PF_IDLE;
        end else begin
            pfState <= pfNext;
        end
    end

    always_comb begin
        pfNext    = pfState;
        pfIssue   = 1'b0;
        pfCapture = 1'b0;
        case (pfState)
            PF_IDLE:  pfNext = PF_IDLE;
            PF_WAITQ: begin
                // Pending writes drain first; only read once the queue is empty.
                if (fifoEmpty && slotFree) begin
                    pfIssue = 1'b1;
                    pfNext  = PF_ISSUE;
                end
            end
            PF_ISSUE: pfNext = PF_CAPT;
            PF_CAPT: begin
                pfCapture = 1'b1;
                pfNext    = PF_IDLE;
            end
        endcase
        if (p0Write) begin
            pfNext    = PF_IDLE;
            pfIssue   = 1'b0;
            pfCapture = 1'b0;
        end else if (pfStart) begin
            pfNext    = PF_WAITQ;
            pfIssue   = 1'b0;
            pfCapture = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addrPtr     <= '0;
            regPhase    <= 1'b0;
            regLatch    <= 8'h00;
            readBuf     <= 8'h00;
            readValid   <= 1'b0;
            overflow    <= 1'b0;
            cpuDataOut  <= 8'h00;
            vramAddress <= '0;
            vramDataOut <= 8'h00;
            vramWrite   <= 1'b0;
            regWrite    <= 1'b0;
            regIndex    <= 3'd0;
            regData     <= 8'h00;
        end else begin
            vramWrite <= 1'b0;
            regWrite  <= 1'b0;

            if (pop) begin
                vramAddress <= fifoHead[RamBits+7:8];
                vramDataOut <= fifoHead[7:0];
                vramWrite   <= 1'b1;
            end else if (pfIssue) begin
                vramAddress <= addrPtr;
            end

            if (pfCapture) begin
                readBuf   <= vramDataIn;
                readValid <= 1'b1;
            end

            if (cpuWrite) begin
                case (cpuAddr)
                    PORT_DATA: begin
                        if (!fifoFull) begin
                            addrPtr   <= addrPtr + 1'b1;
                            readValid <= 1'b0;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    PORT_ADDR_LO: begin
                        addrPtr[7:0] <= cpuDataIn;
                        regPhase     <= 1'b0;
                    end
                    PORT_ADDR_HI: begin
                        addrPtr[RamBits-1:8] <= cpuDataIn[RamBits-9:0];
                        regPhase             <= 1'b0;
                    end
                    PORT_REG: begin
                        if (!regPhase) begin
                            regLatch <= cpuDataIn;
                            regPhase <= 1'b1;
                        end else begin
                            regPhase <= 1'b0;
                            if (cpuDataIn[7]) begin
                                regWrite <= 1'b1;
                                regIndex <= cpuDataIn[2:0];
                                regData  <= regLatch;
                            end
                        end
                    end
                endcase
            end else if (cpuRead) begin
                if (cpuAddr == PORT_DATA) begin
                    cpuDataOut <= readBuf;
                    addrPtr    <= addrPtr + 1'b1;
                    readValid  <= 1'b0;
                end else begin
                    cpuDataOut <= pack_status(fifoFull, fifoEmpty, readValid, overflow, regPhase);
                    overflow   <= 1'b0;
                end
            end
        end
    end

endmodule
